if_stage: RTL and testbench

- Instruction-fetch stage of the 5-stage MIPS pipeline.
- Owns the PC and issues one instruction-memory request at a time to a variable-latency memory.
- Fills the IF/ID pipeline register whose instr[31:26]/instr[5:0] fields drive the control decoder's opcode/funct inputs.
- Honours `stall` from the hazard unit and `redirect` from branch/jump/JR resolution.

---
 rtl/if_stage.sv | 117 +++++++++++
 tb/tb_if_stage.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// MIPS instruction-fetch stage: owns the PC, keeps one request in flight to a
// variable-latency instruction memory, and fills the IF/ID pipeline register.
module if_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        CLK,
   input  logic        RSTn,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        if_id_valid,
   output logic [31:0] if_id_instr,
   output logic [31:0] if_id_pc,
   output logic [31:0] if_id_pc4
);

   typedef enum logic [1:0] {REQ, WAIT, DRAIN, HOLD} state_t;

   state_t      state, state_nxt;
   logic [31:0] pc, pc_nxt, pc_inc, tgt;
   logic [31:0] skid, skid_nxt;
   logic [31:0] ld_instr;
   logic        ld, load_ok;

   assign pc_inc    = pc + 32'd4;
   assign tgt       = redirect_pc & 32'hFFFF_FFFC;
   assign load_ok   = !stall || !if_id_valid;
   assign imem_req  = (state == REQ);
   assign imem_addr = pc;

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         state <= REQ;
         pc    <= RESET_PC & 32'hFFFF_FFFC;
         skid  <= 32'h0;
      end else begin
         state <= state_nxt;
         pc    <= pc_nxt;
         skid  <= skid_nxt;
      end
   end

   // DRAIN swallows the response to a request made obsolete by a redirect.
   always_comb begin
      state_nxt = state;
      pc_nxt    = pc;
      skid_nxt  = skid;
      ld        = 1'b0;
      ld_instr  = imem_rdata;
      case (state)
         REQ: begin
            if (redirect) pc_nxt = tgt;
            if (imem_ready) state_nxt = redirect ? DRAIN : WAIT;
         end
         WAIT: begin
            if (redirect) begin
               pc_nxt    = tgt;
               state_nxt = imem_rvalid ? REQ : DRAIN;
            end else if (imem_rvalid) begin
               if (load_ok) begin
                  ld        = 1'b1;
                  pc_nxt    = pc_inc;
                  state_nxt = REQ;
               end else begin
                  skid_nxt  = imem_rdata;
                  state_nxt = HOLD;
               end
            end
         end
         DRAIN: begin
            if (redirect) pc_nxt = tgt;
            if (imem_rvalid) state_nxt = REQ;
         end
         HOLD: begin
            if (redirect) begin
               pc_nxt    = tgt;
               state_nxt = REQ;
            end else if (load_ok) begin
               ld        = 1'b1;
               ld_instr  = skid;
               pc_nxt    = pc_inc;
               state_nxt = REQ;
            end
         end
         default: state_nxt = REQ;
      endcase
   end

   // Redirect flush beats stall; an empty cycle becomes a NOP bubble.
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         if_id_valid <= 1'b0;
         if_id_instr <= 32'h0;
         if_id_pc    <= 32'h0;
         if_id_pc4   <= 32'h0;
      end else if (redirect) begin
         if_id_valid <= 1'b0;
         if_id_instr <= 32'h0;
      end else if (stall && if_id_valid) begin
         if_id_valid <= if_id_valid;
      end else if (ld) begin
         if_id_valid <= 1'b1;
         if_id_instr <= ld_instr;
         if_id_pc    <= pc;
         if_id_pc4   <= pc_inc;
      end else begin
         if_id_valid <= 1'b0;
         if_id_instr <= 32'h0;
      end
   end

endmodule

// File: tb/tb_if_stage.sv
// Randomized bench for if_stage: a transaction-level fetch model and a
// variable-latency memory responder predict the IF/ID register every cycle.
module tb_if_stage;

   logic        CLK = 1'b0;
   logic        RSTn;
   logic        imem_req, imem_ready, imem_rvalid;
   logic [31:0] imem_addr, imem_rdata, redirect_pc;
   logic        stall, redirect;
   logic        if_id_valid;
   logic [31:0] if_id_instr, if_id_pc, if_id_pc4;

   if_stage #(.RESET_PC(32'h0000_0000)) dut (
      .CLK(CLK), .RSTn(RSTn),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
      .if_id_valid(if_id_valid), .if_id_instr(if_id_instr),
      .if_id_pc(if_id_pc), .if_id_pc4(if_id_pc4)
   );

   always #5 CLK = ~CLK;

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // fetch model: pc, one in-flight fetch (possibly doomed), one parked word
   logic [31:0] m_pc, m_buf;
   bit          m_busy, m_discard, m_have;
   logic        e_v;
   logic [31:0] e_instr, e_pc, e_pc4;
   // memory responder
   bit          mem_pend;
   int          mem_lat;
   logic [31:0] mem_addr;

   function automatic logic [31:0] memf(input logic [31:0] a);
      if (a == 32'h0) return 32'h2408_0005;
      if (a == 32'h4) return 32'h0000_0000;
      return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   task automatic model_reset();
      m_pc = 32'h0; m_buf = 32'h0;
      m_busy = 0; m_discard = 0; m_have = 0;
      e_v = 0; e_instr = 0; e_pc = 0; e_pc4 = 0;
      mem_pend = 0; mem_lat = 0; mem_addr = 0;
   endtask

   task automatic step(input bit s, input bit r, input logic [31:0] rpc,
                       input bit rdy, input int lat, input bit junk);
      logic [31:0] rp, ni, opc, acc_addr;
      bit lok, nl, acc;
      @(negedge CLK);
      chk("if_id_valid", if_id_valid, e_v);
      chk("if_id_instr", if_id_instr, e_instr);
      chk("if_id_pc", if_id_pc, e_pc);
      chk("if_id_pc4", if_id_pc4, e_pc4);
      chk("imem_req", imem_req, !m_busy && !m_have);
      chk("imem_addr", imem_addr, m_pc);
      stall = s; redirect = r; redirect_pc = rpc; imem_ready = rdy;
      if (mem_pend && mem_lat == 0) begin
         imem_rvalid = 1'b1; imem_rdata = memf(mem_addr);
      end else if (junk && !mem_pend && !m_busy && !m_have) begin
         imem_rvalid = 1'b1; imem_rdata = $urandom;
      end else begin
         imem_rvalid = 1'b0; imem_rdata = $urandom;
      end
      acc = imem_req && rdy;
      acc_addr = imem_addr;
      @(posedge CLK);
      rp  = rpc & 32'hFFFF_FFFC;
      lok = !s || !e_v;
      nl  = 0; ni = 32'h0;
      opc = m_pc;
      if (!m_busy && !m_have) begin
         if (rdy) begin m_busy = 1; m_discard = r; end
         if (r) m_pc = rp;
      end else if (m_busy) begin
         if (imem_rvalid) begin
            m_busy = 0;
            if (m_discard || r) begin
               if (r) m_pc = rp;
            end else if (lok) begin
               nl = 1; ni = imem_rdata; m_pc = opc + 32'd4;
            end else begin
               m_have = 1; m_buf = imem_rdata;
            end
         end else if (r) begin
            m_pc = rp; m_discard = 1;
         end
      end else begin
         if (r) begin
            m_have = 0; m_pc = rp;
         end else if (lok) begin
            nl = 1; ni = m_buf; m_have = 0; m_pc = opc + 32'd4;
         end
      end
      if (r) begin
         e_v = 0; e_instr = 0;
      end else if (s && e_v) begin
         e_v = e_v;
      end else if (nl) begin
         e_v = 1; e_instr = ni; e_pc = opc; e_pc4 = opc + 32'd4;
      end else begin
         e_v = 0; e_instr = 0;
      end
      if (mem_pend && imem_rvalid) mem_pend = 0;
      else if (mem_pend && mem_lat > 0) mem_lat--;
      if (acc) begin mem_pend = 1; mem_lat = lat; mem_addr = acc_addr; end
   endtask

   task automatic check_reset_values(input string tag);
      chk({tag, "_valid"}, if_id_valid, 1'b0);
      chk({tag, "_instr"}, if_id_instr, 32'h0);
      chk({tag, "_pc"}, if_id_pc, 32'h0);
      chk({tag, "_pc4"}, if_id_pc4, 32'h0);
      chk({tag, "_req"}, imem_req, 1'b1);
      chk({tag, "_addr"}, imem_addr, 32'h0);
   endtask

   // reset dropped mid-cycle with a response landing while it is held
   task automatic reset_mid();
      @(negedge CLK);
      #2 RSTn = 1'b0;
      #1 check_reset_values("rst_async");
      stall = 0; redirect = 0; imem_ready = 1;
      imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
      @(posedge CLK);
      #2 RSTn = 1'b1;
      imem_rvalid = 1'b0; imem_ready = 1'b0;
      model_reset();
   endtask

   initial begin
      RSTn = 1'b0; stall = 0; redirect = 0; redirect_pc = 0;
      imem_ready = 0; imem_rvalid = 0; imem_rdata = 0;
      model_reset();
      repeat (2) @(posedge CLK);
      #2 RSTn = 1'b1;

      // zero-wait memory from reset
      step(0, 0, 0, 1, 0, 0);
      step(0, 0, 0, 1, 0, 0);
      #1 chk("first_instr", if_id_instr, 32'h2408_0005);
      chk("first_pc4", if_id_pc4, 32'h4);
      repeat (5) step(0, 0, 0, 1, 0, 0);
      // stall while a response arrives -> skid, then release
      repeat (3) step(1, 0, 0, 1, 0, 0);
      repeat (4) step(0, 0, 0, 1, 0, 0);
      // redirect with a slow response outstanding
      step(0, 0, 0, 1, 2, 0);
      step(0, 1, 32'h0000_0100, 1, 0, 0);
      repeat (6) step(0, 0, 0, 1, 0, 0);
      // redirect together with stall
      step(1, 0, 0, 1, 0, 0);
      step(1, 1, 32'h0000_0040, 1, 0, 0);
      repeat (4) step(0, 0, 0, 1, 0, 0);
      // wrap past the top of the address space
      step(0, 1, 32'hFFFF_FFFE, 1, 0, 0);
      repeat (8) step(0, 0, 0, 1, 0, 0);
      // reset while waiting on memory, stale response after release
      step(0, 0, 0, 1, 3, 0);
      step(0, 0, 0, 1, 3, 0);
      reset_mid();
      step(0, 0, 0, 0, 0, 1);
      repeat (6) step(0, 0, 0, 1, 1, 0);

      for (int i = 0; i < 3000; i++) begin
         logic [31:0] rpc;
         rpc = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'h0000_0FFF);
         step($urandom_range(0, 9) < 3, $urandom_range(0, 99) < 8, rpc,
              $urandom_range(0, 9) < 7, $urandom_range(0, 3), $urandom_range(0, 4) == 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
